// File: rtl/npu_operand_sequencer.sv
// Operand sequencer for the NPU core: buffers {input, weight} pairs and issues one core op at a time.
// Optional watchdog abort of a stuck WAIT is enabled by defining NPU_SEQ_TIMEOUT_EN.
module npu_operand_sequencer #(
  parameter int DATA_W      = 4,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [DATA_W-1:0]          in_weight,
  output logic                       core_start,
  output logic [DATA_W-1:0]          core_input,
  output logic [DATA_W-1:0]          core_weight,
  input  logic                       core_done,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [7:0]                 issued_cnt,
  output logic                       busy,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] in_mem_r [DEPTH];
  logic [DATA_W-1:0] wt_mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              core_start_r;
  logic [DATA_W-1:0] core_input_r;
  logic [DATA_W-1:0] core_weight_r;
  logic [7:0]        issued_cnt_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  // FIFO status and handshake decode
  always_comb begin
    full_s  = (count_r == CW'(DEPTH));
    empty_s = (count_r == {CW{1'b0}});
    push_s  = in_valid && !full_s;
    pop_s   = (state_r == IDLE) && !empty_s;
  end

  // FIFO storage; contents are don't-care until written so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      in_mem_r[wr_ptr_r] <= in_data;
      wt_mem_r[wr_ptr_r] <= in_weight;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef NPU_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wdog_r;
  logic           err_r;
`endif

  // Issue FSM; core_start is registered high exactly for the ISSUE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      core_start_r  <= 1'b0;
      core_input_r  <= {DATA_W{1'b0}};
      core_weight_r <= {DATA_W{1'b0}};
      issued_cnt_r  <= 8'd0;
`ifdef NPU_SEQ_TIMEOUT_EN
      wdog_r        <= {WDW{1'b0}};
      err_r         <= 1'b0;
`endif
    end else begin
      core_start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            core_input_r  <= in_mem_r[rd_ptr_r];
            core_weight_r <= wt_mem_r[rd_ptr_r];
            core_start_r  <= 1'b1;
            state_r       <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (core_done) begin
            issued_cnt_r <= issued_cnt_r + 8'd1;
            state_r      <= IDLE;
          end else begin
            state_r <= WAIT;
`ifdef NPU_SEQ_TIMEOUT_EN
            wdog_r  <= {WDW{1'b0}};
`endif
          end
        end
        WAIT: begin
          // A done on the timeout cycle still counts as a normal completion
          if (core_done) begin
            issued_cnt_r <= issued_cnt_r + 8'd1;
            state_r      <= IDLE;
`ifdef NPU_SEQ_TIMEOUT_EN
          end else if (wdog_r == WDW'(TIMEOUT_CYC - 1)) begin
            err_r   <= 1'b1;
            state_r <= IDLE;
          end else begin
            wdog_r  <= wdog_r + WDW'(1'b1);
            state_r <= WAIT;
          end
`else
          end else begin
            state_r <= WAIT;
          end
`endif
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = !full_s;
  assign core_start  = core_start_r;
  assign core_input  = core_input_r;
  assign core_weight = core_weight_r;
  assign fifo_count  = count_r;
  assign issued_cnt  = issued_cnt_r;
  assign busy        = (state_r != IDLE) || !empty_s;
`ifdef NPU_SEQ_TIMEOUT_EN
  assign err         = err_r;
`else
  assign err         = 1'b0;
`endif

endmodule
